char_motion_ctrl: RTL and testbench

Per-frame player-movement controller sitting directly upstream of frameDrawer. It converts keyboard keycodes into the character sprite controls (charIsMoving, charIsRunning, direction, charMoveFrame) and a tile-quantised pixel position on the gym map. All state advances once per video frame, on VGA_VS edges detected inside the Clk domain. The block is active only while the game FSM is in draw_main_game (state_num == 3).

---
 rtl/char_pkg.sv | 66 ++++++
 rtl/vs_tick_gen.sv | 38 +++
 rtl/char_motion_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_char_motion_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// char_pkg: shared definitions for the player-movement path.
// Holds the direction and motion-state encodings, the USB HID keycodes for
// the walk (WASD) and run (arrow) sets, the tile/speed/animation constants,
// and a keycode decoder. frameDrawer imports the same package so the
// direction encoding cannot drift between producer and consumer.
package char_pkg;

    // Sprite-sheet row order used by frameDrawer.
    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        STEP = 2'd2
    } motion_state_t;

    // Walk keys (WASD).
    localparam logic [7:0] KEY_WALK_UP    = 8'h1A;
    localparam logic [7:0] KEY_WALK_DOWN  = 8'h16;
    localparam logic [7:0] KEY_WALK_LEFT  = 8'h04;
    localparam logic [7:0] KEY_WALK_RIGHT = 8'h07;

    // Run keys (arrows).
    localparam logic [7:0] KEY_RUN_UP     = 8'h52;
    localparam logic [7:0] KEY_RUN_DOWN   = 8'h51;
    localparam logic [7:0] KEY_RUN_LEFT   = 8'h50;
    localparam logic [7:0] KEY_RUN_RIGHT  = 8'h4F;

    localparam int TILE        = 16;  // pixels per step
    localparam int WALK_SPEED  = 1;   // pixels per frame tick
    localparam int RUN_SPEED   = 2;   // pixels per frame tick
    localparam int TURN_FRAMES = 4;   // ticks spent turning in place
    localparam int ANIM_DIV    = 4;   // ticks per walk-cycle frame
    localparam int ANIM_FRAMES = 3;   // walk-cycle length (0,1,2)

    typedef struct packed {
        logic valid;  // a movement key is pressed
        logic run;    // arrow key rather than WASD
        dir_t dir;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] kc);
        key_t k;
        k.valid = 1'b1;
        k.run   = 1'b0;
        k.dir   = DOWN;
        case (kc)
            KEY_WALK_UP:    k.dir = UP;
            KEY_WALK_DOWN:  k.dir = DOWN;
            KEY_WALK_LEFT:  k.dir = LEFT;
            KEY_WALK_RIGHT: k.dir = RIGHT;
            KEY_RUN_UP:     begin k.run = 1'b1; k.dir = UP;    end
            KEY_RUN_DOWN:   begin k.run = 1'b1; k.dir = DOWN;  end
            KEY_RUN_LEFT:   begin k.run = 1'b1; k.dir = LEFT;  end
            KEY_RUN_RIGHT:  begin k.run = 1'b1; k.dir = RIGHT; end
            default:        k.valid = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/vs_tick_gen.sv
// vs_tick_gen: turns the asynchronous VGA vertical sync into a one-Clk
// frame tick. Two flops synchronise VGA_VS, a third holds the previous
// synchronised value, and the rising edge is registered, so tick rises
// 3 Clk after the VS rise and lasts exactly one Clk however long VS stays high.
// Ports:
//   Clk   in  system clock
//   Reset in  synchronous active-high reset (clears all flops)
//   vs    in  raw vertical sync, asynchronous to Clk
//   tick  out one-Clk pulse per VS rising edge
module vs_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic vs,
    output logic tick
);

    logic vs_meta;
    logic vs_sync;
    logic vs_prev;
    logic tick_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            vs_meta <= vs;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            tick_q  <= vs_sync & ~vs_prev;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: per-frame player-movement controller feeding frameDrawer.
// Keycodes are decoded into a direction and walk/run speed; an IDLE/TURN/STEP
// FSM advances once per frame tick (only while state_num == 3) and moves the
// character one tile at a time, turning in place first when the key points
// away from the current facing.
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   VGA_VS         vertical sync, asynchronous to Clk
//   state_num      game FSM state; 3 = draw_main_game
//   keycode        USB HID keycode, 0 = none
//   charIsMoving   high while stepping
//   charIsRunning  current/last step was a run step
//   direction      0 down, 1 up, 2 left, 3 right
//   charMoveFrame  walk-cycle frame 0..2
//   char_x, char_y top-left map position in pixels
//   step_done      one-Clk pulse on the tick a step completes
module char_motion_ctrl
    import char_pkg::*;
#(
    parameter logic [9:0] START_X = 10'd224,
    parameter logic [9:0] START_Y = 10'd362,
    parameter int         MIN_X   = 0,
    parameter int         MAX_X   = 448,
    parameter int         MIN_Y   = 0,
    parameter int         MAX_Y   = 448
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VGA_VS,
    input  logic [3:0] state_num,
    input  logic [7:0] keycode,
    output logic       charIsMoving,
    output logic       charIsRunning,
    output logic [1:0] direction,
    output logic [1:0] charMoveFrame,
    output logic [9:0] char_x,
    output logic [9:0] char_y,
    output logic       step_done
);

    // Bounds are checked in signed 12-bit so a target above the top/left edge
    // is negative instead of wrapping to a large legal-looking value.
    localparam logic signed [11:0] TILE_S  = 12'(TILE);
    localparam logic signed [11:0] MIN_X_S = 12'(MIN_X);
    localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
    localparam logic signed [11:0] MIN_Y_S = 12'(MIN_Y);
    localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);

    function automatic logic target_ok(input dir_t d, input logic [9:0] px,
                                       input logic [9:0] py);
        logic signed [11:0] tx;
        logic signed [11:0] ty;
        tx = $signed({2'b00, px});
        ty = $signed({2'b00, py});
        case (d)
            DOWN:    ty = ty + TILE_S;
            UP:      ty = ty - TILE_S;
            LEFT:    tx = tx - TILE_S;
            default: tx = tx + TILE_S;
        endcase
        return (tx >= MIN_X_S) && (tx <= MAX_X_S) && (ty >= MIN_Y_S) && (ty <= MAX_Y_S);
    endfunction

    logic tick;
    logic advance;
    key_t key;

    vs_tick_gen u_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .vs    (VGA_VS),
        .tick  (tick)
    );

    assign advance = tick && (state_num == 4'd3);
    assign key     = decode_key(keycode);

    motion_state_t state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [9:0]    x_mv, y_mv;
    logic [3:0]    cnt_q, cnt_d;     // turn or step ticks remaining minus one
    logic [1:0]    anim_q, anim_d;   // ticks into the current walk-cycle frame
    logic [1:0]    frame_q, frame_d;
    logic          run_q, run_d;
    logic          moving_q, moving_d;
    logic          done_q, done_d;
    logic          load_turn, load_step;

    // Position after one tick of movement at the latched speed.
    always_comb begin
        logic [9:0] amt;
        amt  = run_q ? 10'(RUN_SPEED) : 10'(WALK_SPEED);
        x_mv = x_q;
        y_mv = y_q;
        case (dir_q)
            DOWN:    y_mv = y_q + amt;
            UP:      y_mv = y_q - amt;
            LEFT:    x_mv = x_q - amt;
            default: x_mv = x_q + amt;
        endcase
    end

    // State register (plus datapath registers that move with it).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            dir_q    <= DOWN;
            x_q      <= START_X;
            y_q      <= START_Y;
            cnt_q    <= '0;
            anim_q   <= '0;
            frame_q  <= '0;
            run_q    <= 1'b0;
            moving_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (advance) begin
                state_q  <= state_d;
                dir_q    <= dir_d;
                x_q      <= x_d;
                y_q      <= y_d;
                cnt_q    <= cnt_d;
                anim_q   <= anim_d;
                frame_q  <= frame_d;
                run_q    <= run_d;
                moving_q <= moving_d;
                done_q   <= done_d;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        load_turn = 1'b0;
        load_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (key.valid) begin
                    if (key.dir != dir_q) begin
                        load_turn = 1'b1;
                        state_d   = TURN;
                    end else if (target_ok(dir_q, x_q, y_q)) begin
                        load_step = 1'b1;
                        state_d   = STEP;
                    end
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) state_d = IDLE;
            end
            STEP: begin
                // Keys are only looked at on the final tick; a held key
                // chains straight into the next step from the end position.
                if (cnt_q == 4'd0) begin
                    if (key.valid && (key.dir == dir_q) && target_ok(dir_q, x_mv, y_mv)) begin
                        load_step = 1'b1;
                        state_d   = STEP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        anim_d   = anim_q;
        frame_d  = frame_q;
        run_d    = run_q;
        done_d   = 1'b0;

        case (state_q)
            TURN: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            STEP: begin
                x_d = x_mv;
                y_d = y_mv;
                if (anim_q == 2'(ANIM_DIV - 1)) begin
                    anim_d  = 2'd0;
                    frame_d = (frame_q == 2'(ANIM_FRAMES - 1)) ? 2'd0 : frame_q + 2'd1;
                end else begin
                    anim_d = anim_q + 2'd1;
                end
                if (cnt_q == 4'd0) done_d = 1'b1;
                else               cnt_d  = cnt_q - 4'd1;
            end
            default: ;
        endcase

        if (load_turn) begin
            dir_d = key.dir;
            cnt_d = 4'(TURN_FRAMES - 1);
        end
        if (load_step) begin
            run_d = key.run;
            cnt_d = key.run ? 4'(TILE / RUN_SPEED - 1) : 4'(TILE / WALK_SPEED - 1);
        end
        if ((state_q == STEP) && (state_d == IDLE)) begin
            anim_d  = 2'd0;
            frame_d = 2'd0;
        end
        moving_d = (state_d == STEP);
    end

    assign charIsMoving  = moving_q;
    assign charIsRunning = run_q;
    assign direction     = dir_q;
    assign charMoveFrame = frame_q;
    assign char_x        = x_q;
    assign char_y        = y_q;
    assign step_done     = done_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Bench for char_motion_ctrl: frames are driven on VGA_VS, a behavioural
// model predicts the outputs after each frame tick and queues them, and a
// monitor compares the DUT outputs one Clk after each tick.
module tb_char_motion_ctrl;

    localparam int W = 27;

    logic       Clk;
    logic       Reset;
    logic       VGA_VS;
    logic [3:0] state_num;
    logic [7:0] keycode;
    logic       charIsMoving;
    logic       charIsRunning;
    logic [1:0] direction;
    logic [1:0] charMoveFrame;
    logic [9:0] char_x;
    logic [9:0] char_y;
    logic       step_done;

    char_motion_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .VGA_VS        (VGA_VS),
        .state_num     (state_num),
        .keycode       (keycode),
        .charIsMoving  (charIsMoving),
        .charIsRunning (charIsRunning),
        .direction     (direction),
        .charMoveFrame (charMoveFrame),
        .char_x        (char_x),
        .char_y        (char_y),
        .step_done     (step_done)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int done_seen = 0;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [W-1:0] dut_word();
        return {step_done, charIsMoving, charIsRunning, direction, charMoveFrame, char_x, char_y};
    endfunction

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_TURN = 1, M_STEP = 2;
    int m_x, m_y, m_dir, m_mode, m_turn_left, m_step_left, m_speed, m_ticks, m_done_cnt;
    bit m_run, m_done;
    int kdir_tab[256];
    bit krun_tab[256];

    function automatic void model_init_keys();
        for (int i = 0; i < 256; i++) begin
            kdir_tab[i] = -1;
            krun_tab[i] = 1'b0;
        end
        kdir_tab[8'h16] = 0; kdir_tab[8'h1A] = 1; kdir_tab[8'h04] = 2; kdir_tab[8'h07] = 3;
        kdir_tab[8'h51] = 0; kdir_tab[8'h52] = 1; kdir_tab[8'h50] = 2; kdir_tab[8'h4F] = 3;
        krun_tab[8'h51] = 1; krun_tab[8'h52] = 1; krun_tab[8'h50] = 1; krun_tab[8'h4F] = 1;
    endfunction

    function automatic void model_reset();
        m_x = 224; m_y = 362; m_dir = 0; m_mode = M_IDLE;
        m_turn_left = 0; m_step_left = 0; m_speed = 1; m_ticks = 0;
        m_run = 0; m_done = 0;
    endfunction

    function automatic bit legal(input int x, input int y, input int d);
        int tx = x;
        int ty = y;
        if (d == 0) ty += 16;
        if (d == 1) ty -= 16;
        if (d == 2) tx -= 16;
        if (d == 3) tx += 16;
        return (tx >= 0) && (tx <= 448) && (ty >= 0) && (ty <= 448);
    endfunction

    function automatic void start_step(input bit run);
        m_mode      = M_STEP;
        m_run       = run;
        m_speed     = run ? 2 : 1;
        m_step_left = 16 / m_speed;
    endfunction

    function automatic void model_tick();
        int kd;
        bit kr;
        kd = kdir_tab[keycode];
        kr = krun_tab[keycode];
        m_done = 0;
        if (state_num != 4'd3) return;
        if (m_mode == M_IDLE) begin
            if (kd >= 0) begin
                if (kd != m_dir) begin
                    m_dir = kd; m_mode = M_TURN; m_turn_left = 4;
                end else if (legal(m_x, m_y, m_dir)) begin
                    start_step(kr);
                    m_ticks = 0;
                end
            end
        end else if (m_mode == M_TURN) begin
            m_turn_left--;
            if (m_turn_left == 0) m_mode = M_IDLE;
        end else begin
            if (m_dir == 0) m_y += m_speed;
            if (m_dir == 1) m_y -= m_speed;
            if (m_dir == 2) m_x -= m_speed;
            if (m_dir == 3) m_x += m_speed;
            m_step_left--;
            m_ticks++;
            if (m_step_left == 0) begin
                m_done = 1;
                m_done_cnt++;
                if (kd == m_dir && legal(m_x, m_y, m_dir)) start_step(kr);
                else begin
                    m_mode  = M_IDLE;
                    m_ticks = 0;
                end
            end
        end
    endfunction

    function automatic logic [W-1:0] model_word();
        int fr;
        fr = (m_mode == M_STEP) ? (m_ticks / 4) % 3 : 0;
        return {m_done, (m_mode == M_STEP), m_run, 2'(m_dir), 2'(fr), 10'(m_x), 10'(m_y)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic frame(input int hi);
        model_tick();
        exp_q.push_back(model_word());
        VGA_VS = 1'b1;
        repeat (hi) @(posedge Clk);
        #1 VGA_VS = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
    endtask

    task automatic frames(input int n, input logic [7:0] kc);
        keycode = kc;
        for (int i = 0; i < n; i++) frame(3);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
        m_done = 0;
        check("reset_state", dut_word(), model_word());
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge VGA_VS);
            repeat (4) @(posedge Clk);
            #1;
            if (exp_q.size() == 0) check("scoreboard_underflow", dut_word(), ~dut_word());
            else check("frame_outputs", dut_word(), exp_q.pop_front());
        end
    end

    always @(negedge Clk) if (step_done === 1'b1) done_seen++;

    // ---------------- stimulus ----------------
    logic [7:0] key_pool[10];

    initial begin
        key_pool = '{8'h00, 8'h2C, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F};
        model_init_keys();
        m_done_cnt = 0;
        Reset = 1'b1; VGA_VS = 1'b0; keycode = 8'h00; state_num = 4'd0;
        repeat (3) @(posedge Clk);
        #1;
        do_reset();
        state_num = 4'd3;

        // Single walk step down: one frame of S, then released.
        frames(1, 8'h16);
        frames(17, 8'h00);

        // Turn up then walk.
        do_reset();
        frames(24, 8'h1A);
        frames(18, 8'h00);

        // Turn right then chained run steps.
        do_reset();
        frames(30, 8'h4F);
        frames(10, 8'h00);

        // Walk to the right edge, then keep pushing into it.
        do_reset();
        frames(260, 8'h07);
        frames(2, 8'h00);

        // Freeze while the game is in another state mid-step.
        do_reset();
        frames(1, 8'h16);
        frames(5, 8'h00);
        state_num = 4'd4;
        frames(10, 8'h16);
        state_num = 4'd3;
        frames(14, 8'h00);

        // Reset in the middle of a step.
        do_reset();
        frames(1, 8'h16);
        frames(6, 8'h00);
        do_reset();
        frames(3, 8'h00);

        // Long VS high gives exactly one tick; non-movement keys do nothing.
        keycode = 8'h16;
        frame(1000);
        frames(20, 8'h00);
        frames(4, 8'h2C);

        // Randomised segments.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 99) < 3) do_reset();
            if ($urandom_range(0, 9) == 0) begin
                state_num = 4'($urandom_range(4, 15));
                if ($urandom_range(0, 1) == 1) state_num = 4'($urandom_range(0, 2));
            end else begin
                state_num = 4'd3;
            end
            frames($urandom_range(1, 25), key_pool[$urandom_range(0, 9)]);
        end
        state_num = 4'd3;
        frames(20, 8'h00);

        check("step_done_pulses", W'(done_seen), W'(m_done_cnt));
        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
